// File: rtl/mcode_seq.sv
// Microcode sequencer: fetch/decode of 27-bit microwords from an external ROM.
// Optional return stack for CALL/RET enabled by defining MCODE_STACK_EN.
module mcode_seq #(
  parameter int STACK_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        resetl,
  input  logic        clk,
  input  logic        start,
  input  logic [5:0]  entry,
  input  logic [3:0]  cond,
  input  logic [26:0] z,
  output logic [5:0]  a,
  output logic [14:0] ctl,
  output logic        ctl_stb,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] OP_CONT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_LDC  = 3'd5;
  localparam logic [2:0] OP_DJNZ = 3'd6;
  localparam logic [2:0] OP_END  = 3'd7;

  if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_bad_depth
    $error("mcode_seq: STACK_DEPTH must be 1..8");
  end

  state_t      state_q, state_d;
  logic [5:0]  a_q, a_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        clk_prev_q;
  logic        dec_q;

  logic        clk_rise;
  logic [5:0]  tgt;
  logic [2:0]  op;
  logic        c;
  logic [5:0]  a_inc;
  logic [5:0]  cnt_dec;

  assign clk_rise = ~clk_prev_q & clk;
  assign tgt      = z[5:0];
  assign op       = z[8:6];
  assign c        = cond[z[10:9]] ^ z[11];
  assign a_inc    = a_q + 6'd1;
  assign cnt_dec  = cnt_q - 6'd1;

`ifdef MCODE_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [5:0]     stk_q [2**IW];
  logic [SPW-1:0] sp_q, sp_d;
  logic           push;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic           stk_full;
  logic           stk_empty;

  assign wr_idx    = IW'(sp_q);
  assign rd_idx    = IW'(sp_q - SPW'(1));
  assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
  assign stk_empty = (sp_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef MCODE_STACK_EN
    sp_d    = sp_q;
    push    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = entry;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
`ifdef MCODE_STACK_EN
          sp_d    = '0;
`endif
        end
      end
      RUN: begin
        if (dec_q) begin
          unique case (op)
            OP_CONT: a_d = a_inc;
            OP_JMP:  a_d = tgt;
            OP_BR:   a_d = c ? tgt : a_inc;
`ifdef MCODE_STACK_EN
            OP_CALL: begin
              if (stk_full) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b1;
              end else begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
                a_d  = tgt;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b1;
              end else begin
                sp_d = sp_q - SPW'(1);
                a_d  = stk_q[rd_idx];
              end
            end
`else
            OP_CALL: a_d = tgt;
            OP_RET: begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
`endif
            OP_LDC: begin
              cnt_d = tgt;
              a_d   = a_inc;
            end
            OP_DJNZ: begin
              cnt_d = cnt_dec;
              a_d   = (cnt_dec != 6'd0) ? tgt : a_inc;
            end
            OP_END: begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q    <= IDLE;
      a_q        <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
      dec_q      <= 1'b0;
`ifdef MCODE_STACK_EN
      sp_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clk_prev_q <= clk;
      // a word fetched before RUN addressed a stale a, so never decode it
      dec_q      <= clk_rise & (state_q == RUN);
`ifdef MCODE_STACK_EN
      sp_q       <= sp_d;
`endif
    end
  end

`ifdef MCODE_STACK_EN
  always_ff @(posedge sys_clk) begin
    if (push) stk_q[wr_idx] <= a_inc;
  end
`endif

  assign a       = a_q;
  assign ctl     = z[26:12];
  assign ctl_stb = dec_q & (state_q == RUN);
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mcode_seq.sv
// Scoreboard bench for mcode_seq with a behavioural ROM that latches
// rom[a] on each rising edge of the microcode strobe.
module tb_mcode_seq;

  localparam logic [2:0] CONT = 3'd0, JMP = 3'd1, BR = 3'd2, CALL = 3'd3;
  localparam logic [2:0] RET = 3'd4, LDC = 3'd5, DJNZ = 3'd6, ENDW = 3'd7;

  logic        sys_clk = 1'b0;
  logic        resetl = 1'b0;
  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  entry = '0;
  logic [3:0]  cond = '0;
  logic [26:0] z = '0;
  logic [5:0]  a;
  logic [14:0] ctl;
  logic        ctl_stb, busy, done, err;

  logic [26:0] rom [64];
  logic        rom_prev = 1'b1;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int obs_a[$];
  int obs_c[$];

  mcode_seq dut (
    .sys_clk(sys_clk), .resetl(resetl), .clk(clk), .start(start),
    .entry(entry), .cond(cond), .z(z), .a(a), .ctl(ctl),
    .ctl_stb(ctl_stb), .busy(busy), .done(done), .err(err)
  );

  initial forever #5 sys_clk = ~sys_clk;
  initial forever #30 clk = ~clk;

  always @(posedge sys_clk) begin
    rom_prev <= clk;
    if (!rom_prev && clk) z <= rom[a];
  end

  function automatic int expc(input int ad);
    logic [14:0] v;
    v = {6'(ad), 9'h1A5};
    return int'(v);
  endfunction

  task automatic put(input int ad, input logic [2:0] op, input int tgt,
                     input logic [1:0] sel, input logic inv);
    rom[ad] = {15'(expc(ad)), inv, sel, op, 6'(tgt)};
  endtask

  task automatic run(input int ent, output int nd, output bit tmo);
    obs_a.delete();
    obs_c.delete();
    nd = 0;
    tmo = 1'b1;
    @(negedge sys_clk);
    entry = 6'(ent);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (ctl_stb) begin
        obs_a.push_back(int'(a));
        obs_c.push_back(int'(ctl));
      end
      if (done) nd++;
      if (!busy) begin
        tmo = 1'b0;
        break;
      end
      @(negedge sys_clk);
    end
    repeat (3) begin
      @(negedge sys_clk);
      if (done) nd++;
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (a !== 6'd0) begin
      failures++;
      $display("FAIL rst_a got=%0d want=0", a);
    end
    checks++;
    if ({busy, done, err, ctl_stb} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_flags got=%b want=0000", {busy, done, err, ctl_stb});
    end
    resetl = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_linear();
    int nd, e, oa, oc, nstb;
    bit tmo;
    put(5, CONT, 0, 0, 0);
    put(6, CONT, 0, 0, 0);
    put(7, CONT, 0, 0, 0);
    put(8, ENDW, 0, 0, 0);
    exp_q = '{5, 6, 7, 8};
    run(5, nd, tmo);
    checks++;
    if (tmo || obs_a.size() != exp_q.size()) begin
      failures++;
      $display("FAIL lin_len got=%0d want=%0d tmo=%0d", obs_a.size(), exp_q.size(), tmo);
    end
    while (exp_q.size() > 0 && obs_a.size() > 0) begin
      e = exp_q.pop_front();
      oa = obs_a.pop_front();
      oc = obs_c.pop_front();
      checks++;
      if (oa != e || oc != expc(e)) begin
        failures++;
        $display("FAIL lin_seq got a=%0d ctl=%0h want a=%0d ctl=%0h", oa, oc, e, expc(e));
      end
    end
    checks++;
    if (nd != 1 || busy !== 1'b0 || err !== 1'b0 || a !== 6'd8) begin
      failures++;
      $display("FAIL lin_end got done=%0d busy=%b err=%b a=%0d want 1 0 0 8", nd, busy, err, a);
    end
    nstb = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (ctl_stb || done) nstb++;
    end
    checks++;
    if (nstb != 0 || a !== 6'd8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_edges got stb=%0d a=%0d busy=%b want 0 8 0", nstb, a, busy);
    end
  endtask

  task automatic test_branch();
    int nd, e, oa, oc;
    bit tmo;
    logic [3:0] cv [4];
    logic       iv [4];
    int         tk [4];
    cv = '{4'b0100, 4'b0000, 4'b0100, 4'b0000};
    iv = '{1'b0, 1'b0, 1'b1, 1'b1};
    tk = '{20, 11, 11, 20};
    put(11, ENDW, 0, 0, 0);
    put(20, ENDW, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      put(10, BR, 20, 2'd2, iv[k]);
      cond = cv[k];
      exp_q = '{10, tk[k]};
      run(10, nd, tmo);
      checks++;
      if (tmo || nd != 1 || obs_a.size() != exp_q.size()) begin
        failures++;
        $display("FAIL br%0d_len got=%0d done=%0d want=%0d", k, obs_a.size(), nd, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_a.size() > 0) begin
        e = exp_q.pop_front();
        oa = obs_a.pop_front();
        oc = obs_c.pop_front();
        checks++;
        if (oa != e || oc != expc(e)) begin
          failures++;
          $display("FAIL br%0d_seq got a=%0d ctl=%0h want a=%0d ctl=%0h", k, oa, oc, e, expc(e));
        end
      end
    end
    cond = '0;
  endtask

  task automatic test_loop();
    int nd, e, oa, oc;
    bit tmo;
    put(30, LDC, 3, 0, 0);
    put(31, DJNZ, 31, 0, 0);
    put(32, ENDW, 0, 0, 0);
    exp_q = '{30, 31, 31, 31, 32};
    run(30, nd, tmo);
    checks++;
    if (tmo || nd != 1 || obs_a.size() != exp_q.size()) begin
      failures++;
      $display("FAIL loop_len got=%0d done=%0d want=%0d", obs_a.size(), nd, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_a.size() > 0) begin
      e = exp_q.pop_front();
      oa = obs_a.pop_front();
      oc = obs_c.pop_front();
      checks++;
      if (oa != e || oc != expc(e)) begin
        failures++;
        $display("FAIL loop_seq got a=%0d ctl=%0h want a=%0d ctl=%0h", oa, oc, e, expc(e));
      end
    end
  endtask

  task automatic test_stack();
    int nd, e, oa, oc, wdone;
    bit tmo, werr;
    put(40, CALL, 44, 0, 0);
    put(41, ENDW, 0, 0, 0);
    put(44, CALL, 46, 0, 0);
    put(45, RET, 0, 0, 0);
    put(46, CALL, 48, 0, 0);
    put(47, RET, 0, 0, 0);
    put(48, CALL, 50, 0, 0);
    put(49, RET, 0, 0, 0);
    put(50, RET, 0, 0, 0);
    for (int k = 52; k < 57; k++) put(k, CALL, k + 1, 0, 0);
    put(57, ENDW, 0, 0, 0);
    for (int s = 0; s < 2; s++) begin
`ifdef MCODE_STACK_EN
      if (s == 0) exp_q = '{40, 44, 46, 48, 50, 49, 47, 45, 41};
      else        exp_q = '{52, 53, 54, 55, 56};
      wdone = (s == 0) ? 1 : 0;
      werr  = (s == 1);
`else
      if (s == 0) exp_q = '{40, 44, 46, 48, 50};
      else        exp_q = '{52, 53, 54, 55, 56, 57};
      wdone = 1;
      werr  = 1'b0;
`endif
      run((s == 0) ? 40 : 52, nd, tmo);
      checks++;
      if (tmo || obs_a.size() != exp_q.size()) begin
        failures++;
        $display("FAIL stk%0d_len got=%0d want=%0d", s, obs_a.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_a.size() > 0) begin
        e = exp_q.pop_front();
        oa = obs_a.pop_front();
        oc = obs_c.pop_front();
        checks++;
        if (oa != e || oc != expc(e)) begin
          failures++;
          $display("FAIL stk%0d_seq got a=%0d ctl=%0h want a=%0d ctl=%0h", s, oa, oc, e, expc(e));
        end
      end
      checks++;
      if (nd != wdone || err !== werr || busy !== 1'b0) begin
        failures++;
        $display("FAIL stk%0d_end got done=%0d err=%b busy=%b want %0d %b 0", s, nd, err, busy, wdone, werr);
      end
    end
  endtask

  task automatic test_wrap();
    int nd, e, oa, oc;
    bit tmo;
    put(62, CONT, 0, 0, 0);
    put(63, CONT, 0, 0, 0);
    put(0, ENDW, 0, 0, 0);
    put(12, DJNZ, 14, 0, 0);
    put(13, ENDW, 0, 0, 0);
    put(14, LDC, 1, 0, 0);
    put(15, DJNZ, 15, 0, 0);
    put(16, ENDW, 0, 0, 0);
    for (int s = 0; s < 2; s++) begin
      if (s == 0) exp_q = '{62, 63, 0};
      else        exp_q = '{12, 14, 15, 16};
      run((s == 0) ? 62 : 12, nd, tmo);
      checks++;
      if (tmo || nd != 1 || err !== 1'b0 || obs_a.size() != exp_q.size()) begin
        failures++;
        $display("FAIL wrap%0d_len got=%0d done=%0d err=%b want=%0d", s, obs_a.size(), nd, err, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_a.size() > 0) begin
        e = exp_q.pop_front();
        oa = obs_a.pop_front();
        oc = obs_c.pop_front();
        checks++;
        if (oa != e || oc != expc(e)) begin
          failures++;
          $display("FAIL wrap%0d_seq got a=%0d ctl=%0h want a=%0d ctl=%0h", s, oa, oc, e, expc(e));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, nd;
    n = 0;
    nd = 0;
    put(24, JMP, 24, 0, 0);
    @(negedge sys_clk);
    entry = 6'd24;
    start = 1'b1;
    @(negedge sys_clk);
    for (int i = 0; i < 300 && n < 4; i++) begin
      start = 1'b0;
      if (ctl_stb) begin
        n++;
        checks++;
        if (a !== 6'd24) begin
          failures++;
          $display("FAIL rm_addr got=%0d want=24", a);
        end
        if (n == 2) begin
          start = 1'b1;
          entry = 6'd40;
        end
      end
      @(negedge sys_clk);
    end
    start = 1'b0;
    checks++;
    if (n != 4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rm_run got stb=%0d busy=%b want 4 1", n, busy);
    end
    resetl = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (a !== 6'd0 || {busy, done, err, ctl_stb} !== 4'b0000) begin
      failures++;
      $display("FAIL rm_rst got a=%0d flags=%b want 0 0000", a, {busy, done, err, ctl_stb});
    end
    resetl = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (done || ctl_stb) nd++;
    end
    checks++;
    if (nd != 0 || busy !== 1'b0 || a !== 6'd0) begin
      failures++;
      $display("FAIL rm_after got evts=%0d busy=%b a=%0d want 0 0 0", nd, busy, a);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = '0;
    test_reset();
    test_linear();
    test_branch();
    test_loop();
    test_stack();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
